// File: rtl/imem_fetch_port_if.sv
// Fetch/load bus for imem_fetch_port: request and response handshakes plus the program-load port.
// The master side is the PC/fetch logic (or loader); the slave side is the instruction memory.
interface imem_fetch_port_if #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_instr;
  logic              rsp_fault;
  logic              ld_en;
  logic [IDX_W-1:0]  ld_index;
  logic [XLEN-1:0]   ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_index, ld_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_index, ld_data,
    output req_ready, rsp_valid, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/imem_fetch_port.sv
// Byte-addressed instruction memory with a valid/ready fetch port, one-cycle registered read and a load port.
// Define IMEM_FAULT_EN to flag misaligned and out-of-range fetches; otherwise addresses wrap modulo DEPTH words.
module imem_fetch_port #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  imem_fetch_port_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           state_reg, state_next;
  logic [XLEN-1:0]  rsp_instr_reg;
  logic             rsp_fault_reg;
  logic             req_ready_next;
  logic             accept;
  logic             fetch_fault;
  logic [IDX_W-1:0] fetch_idx;
  logic             unused_addr;

  // Every word powers up as a NOP; reset deliberately leaves the program intact.
  logic [XLEN-1:0] mem [DEPTH] = '{default: NOP};

  assign fetch_idx   = bus.req_addr[IDX_W+1:2];
  assign unused_addr = ^bus.req_addr;

`ifdef IMEM_FAULT_EN
  assign fetch_fault = (bus.req_addr[1:0] != 2'b00) ||
                       ((bus.req_addr >> (IDX_W + 2)) != '0);
`else
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    // Loads win over fetches so a write never races a read of the same word.
    req_ready_next = !rst && !bus.ld_en && (state_reg == S_EMPTY || bus.rsp_ready);
    accept         = bus.req_valid && req_ready_next;
    case (state_reg)
      S_EMPTY: if (accept) state_next = S_FULL;
      S_FULL: begin
        if (accept)             state_next = S_FULL;
        else if (bus.rsp_ready) state_next = S_EMPTY;
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_EMPTY;
      rsp_instr_reg <= NOP;
      rsp_fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rsp_instr_reg <= fetch_fault ? NOP : mem[fetch_idx];
        rsp_fault_reg <= fetch_fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.ld_en) mem[bus.ld_index] <= bus.ld_data;
  end

  assign bus.req_ready = req_ready_next;
  assign bus.rsp_valid = (state_reg == S_FULL);
  assign bus.rsp_instr = rsp_instr_reg;
  assign bus.rsp_fault = rsp_fault_reg;
endmodule

// File: tb/tb_imem_fetch_port.sv
// Table-driven bench for imem_fetch_port: vectors drive load/fetch/consume, a queue scoreboards responses.
module tb_imem_fetch_port;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  imem_fetch_port_if #(.XLEN(32), .DEPTH(64), .ADDR_W(32)) bus ();
  imem_fetch_port #(.XLEN(32), .DEPTH(64), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ld;
    logic [5:0]  ld_idx;
    logic [31:0] ld_data;
    logic        rv;
    logic [31:0] addr;
    logic        rr;
    logic        exp_ready;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
    logic [31:0] addr;
  } rsp_t;

  vec_t        vecs [28];
  rsp_t        sb_q [$];
  logic [31:0] model [64];
  logic        exp_valid;

  function automatic vec_t ld_v(input logic [5:0] idx, input logic [31:0] data, input logic rv,
                                input logic [31:0] addr);
    vec_t v;
    v = '{ld: 1'b1, ld_idx: idx, ld_data: data, rv: rv, addr: addr, rr: 1'b1, exp_ready: 1'b0};
    return v;
  endfunction

  function automatic vec_t fe_v(input logic rv, input logic [31:0] addr, input logic rr,
                                input logic exp_ready);
    vec_t v;
    v = '{ld: 1'b0, ld_idx: 6'd0, ld_data: 32'd0, rv: rv, addr: addr, rr: rr, exp_ready: exp_ready};
    return v;
  endfunction

  function automatic logic addr_faults(input logic [31:0] a);
`ifdef IMEM_FAULT_EN
    return (a[1:0] != 2'b00) || (a >= 32'd256);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    rsp_t r;
    logic acc;
    v = vecs[i];
    @(posedge clk);
    #1;
    bus.ld_en     = v.ld;
    bus.ld_index  = v.ld_idx;
    bus.ld_data   = v.ld_data;
    bus.req_valid = v.rv;
    bus.req_addr  = v.addr;
    bus.rsp_ready = v.rr;
    @(negedge clk);
    check($sformatf("req_ready[%0d]", i), 32'(bus.req_ready), 32'(v.exp_ready));
    check($sformatf("rsp_valid[%0d]", i), 32'(bus.rsp_valid), 32'(exp_valid));
    if (exp_valid && sb_q.size() > 0) begin
      r = sb_q[0];
      check($sformatf("rsp_instr[%0d]", i), bus.rsp_instr, r.instr);
      check($sformatf("rsp_fault[%0d]", i), 32'(bus.rsp_fault), 32'(r.fault));
      if (v.rr) begin
        $display("vec %0d: rsp addr=%h instr=%h fault=%0b", i, r.addr, bus.rsp_instr, bus.rsp_fault);
        void'(sb_q.pop_front());
      end
    end
    acc = v.rv && v.exp_ready;
    if (acc) begin
      r.addr  = v.addr;
      r.fault = addr_faults(v.addr);
      r.instr = r.fault ? NOP : model[v.addr[7:2]];
      sb_q.push_back(r);
    end
    if (acc)                    exp_valid = 1'b1;
    else if (exp_valid && v.rr) exp_valid = 1'b0;
    if (v.ld) model[v.ld_idx] = v.ld_data;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) model[k] = NOP;
    exp_valid = 1'b0;

    // Reset and first fetch
    vecs[0]  = ld_v(6'd1, 32'h0010_009F, 1'b0, 32'h0);
    vecs[1]  = fe_v(1'b1, 32'h4, 1'b1, 1'b1);
    vecs[2]  = fe_v(1'b0, 32'h0, 1'b1, 1'b1);
    // Back-to-back
    vecs[3]  = ld_v(6'd0, 32'hA0, 1'b0, 32'h0);
    vecs[4]  = ld_v(6'd1, 32'hA1, 1'b0, 32'h0);
    vecs[5]  = ld_v(6'd2, 32'hA2, 1'b0, 32'h0);
    vecs[6]  = ld_v(6'd3, 32'hA3, 1'b0, 32'h0);
    vecs[7]  = fe_v(1'b1, 32'h0, 1'b1, 1'b1);
    vecs[8]  = fe_v(1'b1, 32'h4, 1'b1, 1'b1);
    vecs[9]  = fe_v(1'b1, 32'h8, 1'b1, 1'b1);
    vecs[10] = fe_v(1'b1, 32'hC, 1'b1, 1'b1);
    vecs[11] = fe_v(1'b0, 32'h0, 1'b1, 1'b1);
    // Backpressure, then release accepts in the same cycle
    vecs[12] = fe_v(1'b1, 32'h8, 1'b1, 1'b1);
    vecs[13] = fe_v(1'b1, 32'h0, 1'b0, 1'b0);
    vecs[14] = fe_v(1'b1, 32'h0, 1'b0, 1'b0);
    vecs[15] = fe_v(1'b1, 32'h0, 1'b0, 1'b0);
    vecs[16] = fe_v(1'b1, 32'h0, 1'b1, 1'b1);
    vecs[17] = fe_v(1'b0, 32'h0, 1'b1, 1'b1);
    // Load priority
    vecs[18] = ld_v(6'd2, 32'h1234_5678, 1'b1, 32'h8);
    vecs[19] = fe_v(1'b1, 32'h8, 1'b1, 1'b1);
    vecs[20] = fe_v(1'b0, 32'h0, 1'b1, 1'b1);
    // Misaligned / out-of-range / wrap
    vecs[21] = fe_v(1'b1, 32'h6, 1'b1, 1'b1);
    vecs[22] = fe_v(1'b1, 32'h100, 1'b1, 1'b1);
    vecs[23] = fe_v(1'b1, 32'h104, 1'b1, 1'b1);
    vecs[24] = fe_v(1'b0, 32'h0, 1'b1, 1'b1);
    // After mid-operation reset
    vecs[25] = fe_v(1'b1, 32'hC, 1'b1, 1'b1);
    vecs[26] = fe_v(1'b1, 32'h8, 1'b1, 1'b1);
    vecs[27] = fe_v(1'b0, 32'h0, 1'b1, 1'b1);

    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    bus.rsp_ready = 1'b1;
    bus.ld_en     = 1'b0;
    bus.ld_index  = 6'd0;
    bus.ld_data   = 32'd0;

    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_instr", bus.rsp_instr, NOP);
    check("reset_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    bus.req_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 25; i++) apply_vec(i);

    // Reset while a response is pending must drop it at once
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hC;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("midrst_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("midrst_valid_before", 32'(bus.rsp_valid), 32'd1);
    check("midrst_instr_before", bus.rsp_instr, 32'hA3);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid_async", 32'(bus.rsp_valid), 32'd0);
    check("midrst_instr_async", bus.rsp_instr, NOP);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    $display("mid-operation reset applied");
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    exp_valid = 1'b0;

    for (int i = 25; i < 28; i++) apply_vec(i);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised, clocked instruction memory for the single-cycle RISC-V core and its successors. It replaces the asynchronous word-array lookup with a byte-addressed fetch port that has a valid/ready handshake, a one-cycle registered read, and a load port for writing program words at run time. Optional fault detection flags misaligned and out-of-range fetches. It sits between the PC/fetch logic and the decoder.

## Interface
- `XLEN`, 32: instruction word width in bits.
- `DEPTH`, 64: number of instruction words. Must be a power of two, ≥ 2.
- `ADDR_W`, 32: byte-address width of `req_addr`.
- `IDX_W`, `$clog2(DEPTH)`: derived word-index width. Not overridable.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  port accepts a request this cycle.
- `req_addr`  in  ADDR_W  byte address of the fetch.
- `rsp_valid`  out  1  response register holds data.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `rsp_instr`  out  XLEN  fetched instruction.
- `rsp_fault`  out  1  fetch faulted. See Configuration.
- `ld_en`  in  1  write `ld_data` into word `ld_index`.
- `ld_index`  in  IDX_W  word index for the load.
- `ld_data`  in  XLEN  word to store.

## Operation
- Storage is a `DEPTH × XLEN` array, initialised at time zero to NOP `0x00000013` in every word. Reset does not clear the array.
- Word index of a fetch = `req_addr[IDX_W+1:2]`.
- A request is accepted when `req_valid && req_ready`.
- `req_ready = !ld_en && (!rsp_valid || rsp_ready)`. The load port has priority: no fetch is accepted in a cycle with `ld_en`=1.
- On accept, the next edge loads `rsp_instr` and `rsp_fault` and sets `rsp_valid`=1.
- If `rsp_valid && rsp_ready` and no new accept occurs, `rsp_valid` clears at the edge.
- If `rsp_valid && rsp_ready` and a new accept occurs in the same cycle, the register reloads and `rsp_valid` stays 1. This gives back-to-back throughput of one fetch per cycle.
- If `rsp_valid && !rsp_ready`, the response holds stable: `rsp_instr` and `rsp_fault` do not change.
- Load: when `ld_en`=1, `mem[ld_index] <= ld_data` at the edge. Any held response register is not altered.
- A fetch to a word accepted on the cycle after a load returns the new data.

## Timing
- Read latency is 1 cycle, from accept edge to `rsp_valid`.
- Reset values: `rsp_valid`=0, `rsp_instr`=`0x00000013`, `rsp_fault`=0.
- `req_ready` is combinational. While `rst`=1 it is driven 0.
- Reset asserted mid-operation: any pending response is discarded immediately (asynchronously). Array contents are retained. No request is accepted until the first edge after `rst` deasserts.
- No combinational path from `req_addr` to `rsp_*`.

## Configuration
- Macro: `IMEM_FAULT_EN`.
- With `IMEM_FAULT_EN` defined, a fetch faults if either condition holds:
  - `req_addr[1:0] != 0`;
  - `req_addr >= DEPTH*4` (the upper address bits are nonzero).
- A faulting fetch sets `rsp_fault`=1 and `rsp_instr`=`0x00000013`. The handshake and latency are unchanged.
- Without `IMEM_FAULT_EN`: `req_addr[1:0]` and the bits above `IDX_W+1` are ignored, so out-of-range addresses wrap modulo `DEPTH` words. `rsp_fault` is tied 0.

## Test plan
- **Reset and first fetch.** Reset, then load word 1 = `0x0010009F`; fetch addr `0x4` with `rsp_ready`=1 → one cycle later `rsp_valid`=1, `rsp_instr`=`0x0010009F`, `rsp_fault`=0.
- **Back-to-back fetches.** Load words 0..3 with `0xA0..0xA3`; request addr 0,4,8,C on consecutive cycles with `rsp_ready`=1 → responses `0xA0..0xA3` on consecutive cycles, `req_ready` stays 1.
- **Backpressure.** Fetch addr 8 with `rsp_ready`=0 for 3 cycles → `rsp_instr` holds `0xA2` and `req_ready`=0; on release, next request is accepted in that same cycle.
- **Load priority.** `ld_en`=1 (index 2, data `0x12345678`) together with `req_valid` addr 8 → `req_ready`=0 that cycle; next-cycle fetch of addr 8 returns `0x12345678`.
- **Faults, `IMEM_FAULT_EN` defined, DEPTH=64.**
  - Fetch addr `0x6` → `rsp_fault`=1, `rsp_instr`=`0x00000013`.
  - Fetch addr `0x100` → `rsp_fault`=1.
- **Wrap, macro undefined, DEPTH=64.** Fetch `0x104` → returns word 1 with `rsp_fault`=0.
- **Reset mid-operation.** Assert `rst` while `rsp_valid`=1 → `rsp_valid`=0 immediately; array contents intact on the next fetch.
